// File: rtl/traffic_pkg.sv
// Shared types and timing defaults for the traffic-light controller.
// FSM encodings are one-hot; bit indices name the state flops.
package traffic_pkg;

  localparam int CLK_HZ           = 16_000_000;
  localparam int DEBOUNCE_CYCLES  = CLK_HZ / 50;
  localparam int MIN_FLASH_CYCLES = 2 * CLK_HZ;

  localparam int ST_DWELL  = 0;
  localparam int ST_FLASH  = 1;
  localparam int ST_NORMAL = 2;

  typedef enum logic [2:0] {
    S_FLASH_DWELL = 3'b001,
    S_FLASH       = 3'b010,
    S_NORMAL      = 3'b100
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// Synchroniser and level debouncer for the maintenance mode pin.
// Counts aborted level changes as glitches.
module switch_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = traffic_pkg::DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_pin,
  output logic       deb_level,
  output logic [7:0] bounce_count
);
  import traffic_pkg::*;

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic [CW-1:0]          db_cnt;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], mode_pin};
    end
  end

  // A nonzero count that collapses back to the held level is a glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_level    <= 1'b0;
      db_cnt       <= '0;
      bounce_count <= '0;
    end else if (sync_lvl == deb_level) begin
      db_cnt <= '0;
      if (db_cnt != '0) begin
        bounce_count <= sat_inc8(bounce_count);
      end
    end else if (db_cnt == CNT_LAST) begin
      deb_level <= sync_lvl;
      db_cnt    <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mode_switch_conditioner.sv
// Conditions the mode-switch pin for the traffic-light controller.
// Flash mode holds for a minimum dwell before normal is allowed.
module mode_switch_conditioner #(
  parameter int SYNC_STAGES      = 2,
  parameter int DEBOUNCE_CYCLES  = traffic_pkg::DEBOUNCE_CYCLES,
  parameter int MIN_FLASH_CYCLES = traffic_pkg::MIN_FLASH_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_pin,
  output logic       mode_out,
  output logic       enter_normal,
  output logic       enter_flash,
  output logic [7:0] bounce_count
);
  import traffic_pkg::*;

  localparam int DW =
    (MIN_FLASH_CYCLES > 1) ? $clog2(MIN_FLASH_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(MIN_FLASH_CYCLES - 1);

  state_t        state;
  state_t        next_state;
  logic          deb_level;
  logic [DW-1:0] dwell_cnt;
  logic          dwell_done;

  switch_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_pin    (mode_pin),
    .deb_level   (deb_level),
    .bounce_count(bounce_count)
  );

  assign dwell_done = (dwell_cnt == DWELL_LAST);
  assign mode_out   = (state == S_NORMAL);

  // Non-one-hot patterns fall back to the safe dwell state
  always_comb begin
    next_state = S_FLASH_DWELL;
    if ($onehot(state)) begin
      unique case (1'b1)
        state[ST_DWELL]: begin
          if (!dwell_done) next_state = S_FLASH_DWELL;
          else if (deb_level) next_state = S_NORMAL;
          else next_state = S_FLASH;
        end
        state[ST_FLASH]: begin
          next_state = deb_level ? S_NORMAL : S_FLASH;
        end
        state[ST_NORMAL]: begin
          next_state = deb_level ? S_NORMAL : S_FLASH_DWELL;
        end
        default: next_state = S_FLASH_DWELL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FLASH_DWELL;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
    end else if (state != S_FLASH_DWELL) begin
      dwell_cnt <= '0;
    end else if (!dwell_done) begin
      dwell_cnt <= dwell_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enter_normal <= 1'b0;
      enter_flash  <= 1'b0;
    end else begin
      enter_normal <= (next_state == S_NORMAL) && (state != S_NORMAL);
      enter_flash  <= (state == S_NORMAL) && (next_state != S_NORMAL);
    end
  end

endmodule

// File: tb/tb_mode_switch_conditioner.sv
// Self-checking bench for mode_switch_conditioner.
// Small-parameter build checked against a timestamp-based model.
module tb_mode_switch_conditioner;
  import traffic_pkg::*;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int MINF = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       mode_pin = 1'b1;
  logic       mode_out;
  logic       enter_normal;
  logic       enter_flash;
  logic [7:0] bounce_count;

  int n_checks = 0;
  int n_fail = 0;

  mode_switch_conditioner #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .MIN_FLASH_CYCLES(MINF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_pin    (mode_pin),
    .mode_out    (mode_out),
    .enter_normal(enter_normal),
    .enter_flash (enter_flash),
    .bounce_count(bounce_count)
  );

  always #5 clk = ~clk;

  // Reference model: pin delay line, run length of disagreement,
  // and the edge number of the last flash entry.
  logic m_pipe [SYNC];
  logic m_deb = 0, m_mode = 0, m_en = 0, m_ef = 0;
  int   m_run = 0, m_bounce = 0, m_tick = 0, m_fall = 0;
  logic sd, dd, md;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
      m_deb = 0; m_mode = 0; m_en = 0; m_ef = 0;
      m_run = 0; m_bounce = 0; m_tick = 0; m_fall = 0;
    end else begin
      m_tick++;
      sd = m_pipe[SYNC-1];
      dd = m_deb;
      md = m_mode;
      if (sd != dd) begin
        m_run++;
        if (m_run == DEB) begin
          m_deb = sd;
          m_run = 0;
        end
      end else begin
        if (m_run > 0 && m_bounce < 255) m_bounce++;
        m_run = 0;
      end
      if (md && !dd) begin
        m_mode = 0;
        m_fall = m_tick;
      end else if (!md && dd && (m_tick - m_fall) >= MINF) begin
        m_mode = 1;
      end
      m_en = !md && m_mode;
      m_ef = md && !m_mode;
      for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = mode_pin;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (mode_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_mode: got %b expected 0", mode_out);
    end
    if (enter_normal !== 1'b0) begin
      n_fail++; $display("FAIL reset_en: got %b expected 0", enter_normal);
    end
    if (enter_flash !== 1'b0) begin
      n_fail++; $display("FAIL reset_ef: got %b expected 0", enter_flash);
    end
    if (bounce_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_bounce: got %0d expected 0", bounce_count);
    end
  endtask

  task automatic test_power_up();
    mode_pin = 1'b1;
    step();
    rst_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      n_checks += 4;
      if (dut.u_deb.deb_level !== (e >= 6)) begin
        n_fail++;
        $display("FAIL pwr_deb e%0d: got %b expected %b",
                 e, dut.u_deb.deb_level, (e >= 6));
      end
      if (mode_out !== (e >= 10) || mode_out !== m_mode) begin
        n_fail++;
        $display("FAIL pwr_mode e%0d: got %b expected %b", e, mode_out, (e >= 10));
      end
      if (enter_normal !== (e == 10)) begin
        n_fail++;
        $display("FAIL pwr_en e%0d: got %b expected %b", e, enter_normal, (e == 10));
      end
      if (enter_flash !== 1'b0) begin
        n_fail++; $display("FAIL pwr_ef e%0d: got %b expected 0", e, enter_flash);
      end
    end
    n_checks++;
    if (bounce_count !== 8'd0) begin
      n_fail++; $display("FAIL pwr_bounce: got %0d expected 0", bounce_count);
    end
  endtask

  task automatic test_glitch();
    logic bad = 0;
    mode_pin = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 2) mode_pin = 1'b1;
      if (mode_out !== 1'b1 || enter_normal || enter_flash) bad = 1;
    end
    n_checks += 2;
    if (bad) begin
      n_fail++; $display("FAIL glitch_mode: output moved, expected steady 1");
    end
    if (bounce_count !== 8'd1) begin
      n_fail++; $display("FAIL glitch_bounce: got %0d expected 1", bounce_count);
    end
  endtask

  task automatic test_hold_low();
    int n = 0;
    int k = 0;
    mode_pin = 1'b0;
    while (mode_out === 1'b1 && n < 20) begin
      step();
      n++;
    end
    n_checks += 2;
    if (n != 7) begin
      n_fail++; $display("FAIL fall_latency: got %0d expected 7", n);
    end
    if (enter_flash !== 1'b1) begin
      n_fail++; $display("FAIL fall_pulse: got %b expected 1", enter_flash);
    end
    step();
    k = 1;
    mode_pin = 1'b1;
    n_checks++;
    if (enter_flash !== 1'b0) begin
      n_fail++; $display("FAIL fall_pulse_len: got %b expected 0", enter_flash);
    end
    while (mode_out !== 1'b1 && k < 30) begin
      step();
      k++;
    end
    n_checks += 2;
    if (k != MINF) begin
      n_fail++; $display("FAIL dwell_len: got %0d expected %0d", k, MINF);
    end
    if (enter_normal !== 1'b1) begin
      n_fail++; $display("FAIL rise_pulse: got %b expected 1", enter_normal);
    end
  endtask

  task automatic test_reset_mid();
    mode_pin = 1'b0;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (mode_out !== 1'b0) begin
      n_fail++; $display("FAIL mid_mode: got %b expected 0", mode_out);
    end
    if (enter_normal !== 1'b0) begin
      n_fail++; $display("FAIL mid_en: got %b expected 0", enter_normal);
    end
    if (enter_flash !== 1'b0) begin
      n_fail++; $display("FAIL mid_ef: got %b expected 0", enter_flash);
    end
    if (bounce_count !== 8'd0) begin
      n_fail++; $display("FAIL mid_bounce: got %0d expected 0", bounce_count);
    end
    mode_pin = 1'b1;
    step();
    test_power_up();
  endtask

  task automatic test_saturation();
    for (int g = 0; g < 300; g++) begin
      logic bad = 0;
      int exp_b = (g + 1 > 255) ? 255 : g + 1;
      mode_pin = 1'b0;
      for (int i = 0; i < 8; i++) begin
        step();
        if (i == 2) mode_pin = 1'b1;
        if (mode_out !== 1'b1 || mode_out !== m_mode) bad = 1;
      end
      n_checks += 2;
      if (bad) begin
        n_fail++; $display("FAIL sat_mode g%0d: output left 1", g);
      end
      if (bounce_count !== 8'(exp_b) || bounce_count !== 8'(m_bounce)) begin
        n_fail++;
        $display("FAIL sat_bounce g%0d: got %0d expected %0d", g, bounce_count, exp_b);
      end
    end
  endtask

  task automatic test_illegal_state();
    step();
    force dut.state = state_t'(3'b000);
    #1;
    n_checks++;
    if (mode_out !== 1'b0) begin
      n_fail++; $display("FAIL illegal_mode0: got %b expected 0", mode_out);
    end
    @(posedge clk);
    #1;
    release dut.state;
    step();
    n_checks += 2;
    if (dut.state !== S_FLASH_DWELL) begin
      n_fail++; $display("FAIL illegal_state: got %b expected 001", dut.state);
    end
    if (mode_out !== 1'b0) begin
      n_fail++; $display("FAIL illegal_mode: got %b expected 0", mode_out);
    end
  endtask

  task automatic test_random();
    int seg = 0;
    int rises = 0;
    rst_n = 1'b0;
    mode_pin = 1'b1;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 900; c++) begin
      if (seg == 0) begin
        mode_pin = 1'($urandom_range(0, 1));
        seg = $urandom_range(1, 14);
      end
      seg--;
      step();
      n_checks += 5;
      if (mode_out !== m_mode) begin
        n_fail++; $display("FAIL rnd_mode c%0d: got %b expected %b", c, mode_out, m_mode);
      end
      if (enter_normal !== m_en) begin
        n_fail++; $display("FAIL rnd_en c%0d: got %b expected %b", c, enter_normal, m_en);
      end
      if (enter_flash !== m_ef) begin
        n_fail++; $display("FAIL rnd_ef c%0d: got %b expected %b", c, enter_flash, m_ef);
      end
      if (bounce_count !== 8'(m_bounce)) begin
        n_fail++;
        $display("FAIL rnd_bounce c%0d: got %0d expected %0d", c, bounce_count, m_bounce);
      end
      if (enter_normal && enter_flash) begin
        n_fail++; $display("FAIL rnd_both c%0d: got 11 expected not both", c);
      end
      if (m_en) rises++;
    end
    $display("random phase: %0d normal entries", rises);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_power_up();
    test_glitch();
    test_hold_low();
    test_reset_mid();
    test_saturation();
    test_illegal_state();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
